// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser, a mid-bit
// sampling FSM and a one-entry valid/ready holding register. Framing errors
// and overruns are reported as single-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_ready,
    output logic [7:0] rx_data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic             r_rx_meta;
    logic             r_rx_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_load;
    logic [7:0]       r_rx_data;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_overrun;

    // Two-flop synchroniser for the asynchronous serial pin; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame FSM: detect start, sample each bit at its centre, check the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    // Leaving at mid-stop-bit keeps a back-to-back start edge visible.
                    if (r_cnt == BIT_M1) begin
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                        r_load      <= r_rx_s;
                        r_frame_err <= ~r_rx_s;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // One-entry holding register: load a good byte, drain on data_ready, flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_load) begin
                if (!r_data_valid || data_ready) begin
                    r_rx_data    <= r_shift;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (data_ready) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
